// File: rtl/ip_udp_hdr_tx.sv
// IPv4 + UDP header builder: captures datagram fields, runs the external checksum unit,
// and streams the 28-byte header byte-serially with a valid/ready handshake.
module ip_udp_hdr_tx #(
   parameter logic [7:0]  IP_TTL      = 8'd64,
   parameter logic [15:0] IP_ID_INIT  = 16'h0000,
   parameter logic [15:0] MAX_PAYLOAD = 16'd65507
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] src_ip,
   input  logic [31:0] dst_ip,
   input  logic [15:0] src_port,
   input  logic [15:0] dst_port,
   input  logic [15:0] data_len,
   output logic        cal_en,
   output logic [15:0] ip_total_len,
   output logic [15:0] ip_id,
   input  logic [15:0] checksum,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        tx_last,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int unsigned IDX_W    = 5;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(27);
   localparam logic [15:0] IP_HDR_LEN  = 16'd28;
   localparam logic [15:0] UDP_HDR_LEN = 16'd8;

   typedef enum logic [2:0] {S_IDLE, S_CALC, S_WAIT, S_SEND, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      src_ip_q, dst_ip_q;
   logic [15:0]      src_port_q, dst_port_q, udp_len_q, csum_q;
   logic [7:0]       hdr_byte;
   logic             accept, reject, hs;
   logic             cal_en_d, tx_valid_d, tx_last_d, busy_d, done_d, err_d;
   logic [7:0]       tx_data_d;

   assign accept = start && (state_q == S_IDLE) && (data_len <= MAX_PAYLOAD);
   assign reject = start && (state_q == S_IDLE) && (data_len >  MAX_PAYLOAD);
   assign hs     = tx_valid && tx_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: if (accept) state_d = S_CALC;
         S_CALC: state_d = S_WAIT;
         S_WAIT: state_d = S_SEND;
         S_SEND: begin
            if (hs) begin
               if (idx_q == LAST_IDX) state_d = S_DONE;
               else                   idx_d   = idx_q + IDX_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Header byte for the index that will be presented next cycle; fields are big-endian.
   always_comb begin
      hdr_byte = 8'h00;
      case (idx_d)
         5'd0:  hdr_byte = 8'h45;
         5'd1:  hdr_byte = 8'h00;
         5'd2:  hdr_byte = ip_total_len[15:8];
         5'd3:  hdr_byte = ip_total_len[7:0];
         5'd4:  hdr_byte = ip_id[15:8];
         5'd5:  hdr_byte = ip_id[7:0];
         5'd6:  hdr_byte = 8'h40;
         5'd7:  hdr_byte = 8'h00;
         5'd8:  hdr_byte = IP_TTL;
         5'd9:  hdr_byte = 8'h11;
         5'd10: hdr_byte = csum_q[15:8];
         5'd11: hdr_byte = csum_q[7:0];
         5'd12: hdr_byte = src_ip_q[31:24];
         5'd13: hdr_byte = src_ip_q[23:16];
         5'd14: hdr_byte = src_ip_q[15:8];
         5'd15: hdr_byte = src_ip_q[7:0];
         5'd16: hdr_byte = dst_ip_q[31:24];
         5'd17: hdr_byte = dst_ip_q[23:16];
         5'd18: hdr_byte = dst_ip_q[15:8];
         5'd19: hdr_byte = dst_ip_q[7:0];
         5'd20: hdr_byte = src_port_q[15:8];
         5'd21: hdr_byte = src_port_q[7:0];
         5'd22: hdr_byte = dst_port_q[15:8];
         5'd23: hdr_byte = dst_port_q[7:0];
         5'd24: hdr_byte = udp_len_q[15:8];
         5'd25: hdr_byte = udp_len_q[7:0];
         default: hdr_byte = 8'h00;
      endcase
   end

   // Output values are decoded from the next state so the registered outputs line up with it.
   always_comb begin
      cal_en_d   = 1'b0;
      tx_valid_d = 1'b0;
      tx_last_d  = 1'b0;
      tx_data_d  = 8'h00;
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
      err_d      = reject;
      case (state_d)
         S_CALC: cal_en_d = 1'b1;
         S_SEND: begin
            tx_valid_d = 1'b1;
            tx_data_d  = hdr_byte;
            tx_last_d  = (idx_d == LAST_IDX);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_q        <= '0;
         src_ip_q     <= '0;
         dst_ip_q     <= '0;
         src_port_q   <= '0;
         dst_port_q   <= '0;
         udp_len_q    <= '0;
         csum_q       <= '0;
         ip_total_len <= '0;
         ip_id        <= IP_ID_INIT;
         cal_en       <= 1'b0;
         tx_valid     <= 1'b0;
         tx_last      <= 1'b0;
         tx_data      <= 8'h00;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
      end else begin
         if (accept) begin
            src_ip_q     <= src_ip;
            dst_ip_q     <= dst_ip;
            src_port_q   <= src_port;
            dst_port_q   <= dst_port;
            ip_total_len <= data_len + IP_HDR_LEN;
            udp_len_q    <= data_len + UDP_HDR_LEN;
         end
         if (state_q == S_WAIT) csum_q <= checksum;
         if (state_q == S_DONE) ip_id  <= ip_id + 16'd1;
         idx_q    <= idx_d;
         cal_en   <= cal_en_d;
         tx_valid <= tx_valid_d;
         tx_last  <= tx_last_d;
         tx_data  <= tx_data_d;
         busy     <= busy_d;
         done     <= done_d;
         err      <= err_d;
      end
   end

endmodule

// File: tb/tb_ip_udp_hdr_tx.sv
// Scoreboard bench for ip_udp_hdr_tx: a behavioural checksum unit feeds each instance,
// expected header bytes are queued at start and compared as bytes are accepted.
module tb_ip_udp_hdr_tx;

   localparam logic [223:0] NOMINAL_HDR =
      224'h4500_002E_0000_4000_4011_B969_C0A8_0002_C0A8_0003_1388_1770_001A_0000;

   logic        clk = 1'b0;
   logic        reset_n, start, start_w, tx_ready;
   logic [31:0] src_ip, dst_ip;
   logic [15:0] src_port, dst_port, data_len;
   logic [15:0] checksum, checksum_w;

   logic        cal_en, tx_valid, tx_last, busy, done, err;
   logic [15:0] ip_total_len, ip_id;
   logic [7:0]  tx_data;
   logic        cal_en_w, tx_valid_w, tx_last_w, busy_w, done_w, err_w;
   logic [15:0] ip_total_len_w, ip_id_w;
   logic [7:0]  tx_data_w;

   int          n_vec = 0, n_err = 0;
   int          cyc = 0, t_start = 0, nbytes = 0, done_cnt = 0;
   bit          bp = 1'b0;
   logic [15:0] exp_id = 16'h0000, exp_id_w = 16'hFFFF;
   logic [8:0]  exp_q[$], exp_w_q[$];

   ip_udp_hdr_tx u_dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .src_ip(src_ip), .dst_ip(dst_ip), .src_port(src_port), .dst_port(dst_port),
      .data_len(data_len), .cal_en(cal_en), .ip_total_len(ip_total_len), .ip_id(ip_id),
      .checksum(checksum), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_last(tx_last), .busy(busy), .done(done), .err(err)
   );

   ip_udp_hdr_tx #(.IP_ID_INIT(16'hFFFF)) u_wrap (
      .clk(clk), .reset_n(reset_n), .start(start_w),
      .src_ip(src_ip), .dst_ip(dst_ip), .src_port(src_port), .dst_port(dst_port),
      .data_len(data_len), .cal_en(cal_en_w), .ip_total_len(ip_total_len_w), .ip_id(ip_id_w),
      .checksum(checksum_w), .tx_data(tx_data_w), .tx_valid(tx_valid_w), .tx_ready(tx_ready),
      .tx_last(tx_last_w), .busy(busy_w), .done(done_w), .err(err_w)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ip_csum(logic [15:0] tl, logic [15:0] id,
                                           logic [31:0] s, logic [31:0] d);
      logic [31:0] sum;
      sum = 32'h4500 + 32'(tl) + 32'(id) + 32'h4000 + 32'h4011
          + 32'(s[31:16]) + 32'(s[15:0]) + 32'(d[31:16]) + 32'(d[15:0]);
      sum = 32'(sum[15:0]) + 32'(sum[31:16]);
      sum = 32'(sum[15:0]) + 32'(sum[31:16]);
      return ~sum[15:0];
   endfunction

   function automatic logic [223:0] hdr_flat(logic [31:0] s, logic [31:0] d, logic [15:0] sp,
                                             logic [15:0] dp, logic [15:0] len, logic [15:0] id);
      logic [15:0] tl, ul;
      tl = len + 16'd28;
      ul = len + 16'd8;
      return {8'h45, 8'h00, tl, id, 8'h40, 8'h00, 8'd64, 8'h11, ip_csum(tl, id, s, d),
              s, d, sp, dp, ul, 16'h0000};
   endfunction

   // Behavioural checksum units: sum register loads on cal_en, valid the following cycle.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         checksum   <= '0;
         checksum_w <= '0;
      end else begin
         if (cal_en)   checksum   <= ip_csum(ip_total_len, ip_id, src_ip, dst_ip);
         if (cal_en_w) checksum_w <= ip_csum(ip_total_len_w, ip_id_w, src_ip, dst_ip);
      end
   end

   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         tx_ready = bp ? ~tx_ready : 1'b1;
      end
   end

   // Monitors: pop on every accepted byte; check that a stalled byte is held.
   initial begin
      logic [8:0] e, held;
      bit         pend;
      pend = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (pend && tx_valid) check("hold", 32'({tx_last, tx_data}), 32'(held));
            pend = tx_valid && !tx_ready;
            held = {tx_last, tx_data};
            if (tx_valid && tx_ready) begin
               if (exp_q.size() == 0) check("extra_byte_qsize", 32'(exp_q.size()), 32'd1);
               else begin
                  e = exp_q.pop_front();
                  check($sformatf("byte%0d", nbytes % 28), 32'({tx_last, tx_data}), 32'(e));
                  nbytes++;
               end
            end
            if (done) done_cnt++;
         end else pend = 1'b0;
      end
   end

   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (reset_n && tx_valid_w && tx_ready) begin
            if (exp_w_q.size() == 0) check("wrap_extra_qsize", 32'(exp_w_q.size()), 32'd1);
            else begin
               e = exp_w_q.pop_front();
               check("wrap_byte", 32'({tx_last_w, tx_data_w}), 32'(e));
            end
         end
      end
   end

   task automatic issue(input bit wrap, input bit lit, input logic [31:0] s, input logic [31:0] d,
                        input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] len);
      logic [223:0] flat;
      @(posedge clk); #1;
      src_ip = s; dst_ip = d; src_port = sp; dst_port = dp; data_len = len;
      if (wrap) start_w = 1'b1;
      else      start   = 1'b1;
      t_start = cyc;
      if (len <= 16'd65507) begin
         flat = lit ? NOMINAL_HDR : hdr_flat(s, d, sp, dp, len, wrap ? exp_id_w : exp_id);
         for (int i = 0; i < 28; i++) begin
            if (wrap) exp_w_q.push_back({1'(i == 27), flat[223-8*i -: 8]});
            else      exp_q.push_back({1'(i == 27), flat[223-8*i -: 8]});
         end
         if (wrap) exp_id_w = exp_id_w + 16'd1;
         else      exp_id   = exp_id + 16'd1;
      end
      @(posedge clk); #1;
      start = 1'b0; start_w = 1'b0;
   endtask

   task automatic wait_done(input string tag, input bit wrap, input int max);
      for (int k = 0; k < max; k++) begin
         @(negedge clk);
         if (wrap ? done_w : done) break;
      end
      check({tag, "_done"}, 32'(wrap ? done_w : done), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0, base;
      reset_n = 1'b0; start = 1'b0; start_w = 1'b0;
      src_ip = '0; dst_ip = '0; src_port = '0; dst_port = '0; data_len = '0;
      repeat (3) @(negedge clk);
      check("rst_outs", 32'({cal_en, tx_valid, tx_last, busy, done, err}), 32'd0);
      check("rst_data", 32'({tx_data, ip_total_len}), 32'd0);
      check("rst_id", 32'(ip_id), 32'h0000);
      check("rst_id_wrap", 32'({ip_id_w, busy_w, err_w}), 32'({16'hFFFF, 2'b00}));
      @(posedge clk); #1; reset_n = 1'b1;

      // Nominal header against the known byte sequence; latency checks.
      issue(1'b0, 1'b1, 32'hC0A8_0002, 32'hC0A8_0003, 16'd5000, 16'd6000, 16'd18);
      for (int k = 0; k < 10 && !tx_valid; k++) @(negedge clk);
      check("first_valid_lat", 32'(cyc - t_start), 32'd3);
      check("busy_in_send", 32'(busy), 32'd1);
      wait_done("nominal", 1'b0, 100);
      check("done_lat", 32'(cyc - t_start), 32'd31);
      check("nominal_q_empty", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      check("id_after_1", 32'(ip_id), 32'h0001);

      // Backpressure on alternate cycles.
      bp = 1'b1;
      issue(1'b0, 1'b0, 32'hC0A8_0002, 32'hC0A8_0003, 16'd5000, 16'd6000, 16'd18);
      wait_done("bp", 1'b0, 200);
      check("bp_q_empty", 32'(exp_q.size()), 32'd0);
      bp = 1'b0;

      // Identification wrap on the FFFF-initialised instance.
      issue(1'b1, 1'b0, 32'h0A00_0001, 32'h0A00_0002, 16'd1234, 16'd80, 16'd100);
      wait_done("wrap1", 1'b1, 100);
      issue(1'b1, 1'b0, 32'h0A00_0001, 32'h0A00_0002, 16'd1234, 16'd80, 16'd100);
      wait_done("wrap2", 1'b1, 100);
      check("wrap_q_empty", 32'(exp_w_q.size()), 32'd0);
      @(negedge clk);
      check("wrap_id", 32'(ip_id_w), 32'h0001);

      // Oversize rejected, then the largest legal payload.
      issue(1'b0, 1'b0, 32'h0102_0304, 32'h0506_0708, 16'd1, 16'd2, 16'd65508);
      @(negedge clk);
      check("err_pulse", 32'({err, busy}), 32'b10);
      d0 = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         d0 += int'(err) + int'(busy) + int'(tx_valid);
      end
      check("oversize_quiet", 32'(d0), 32'd0);
      issue(1'b0, 1'b0, 32'h0102_0304, 32'h0506_0708, 16'd1, 16'd2, 16'd65507);
      @(negedge clk);
      check("max_total_len", 32'(ip_total_len), 32'hFFFF);
      wait_done("maxlen", 1'b0, 100);

      // Start while busy is ignored.
      @(negedge clk); #1;
      d0 = done_cnt;
      issue(1'b0, 1'b0, 32'h1111_2222, 32'h3333_4444, 16'd7, 16'd9, 16'd40);
      repeat (8) @(posedge clk);
      #1;
      src_ip = 32'hDEAD_BEEF; dst_ip = 32'hFEED_F00D; data_len = 16'd3; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      wait_done("busy_start", 1'b0, 100);
      repeat (40) @(negedge clk);
      #1;
      check("busy_done_cnt", 32'(done_cnt - d0), 32'd1);
      check("busy_idle_after", 32'({busy, err}), 32'd0);

      // Reset while presenting byte 12.
      base = nbytes;
      issue(1'b0, 1'b0, 32'hAC10_0001, 32'hAC10_00FE, 16'd4000, 16'd4001, 16'd512);
      for (int k = 0; k < 100 && (nbytes - base) < 12; k++) begin
         @(negedge clk); #1;
      end
      check("reach_idx12", 32'(nbytes - base), 32'd12);
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      check("rst_async_valid", 32'({tx_valid, busy}), 32'd0);
      check("rst_async_id", 32'(ip_id), 32'h0000);
      exp_q.delete(); exp_w_q.delete();
      exp_id = 16'h0000; exp_id_w = 16'hFFFF;
      @(posedge clk); #1; reset_n = 1'b1;
      issue(1'b0, 1'b0, 32'hAC10_0001, 32'hAC10_00FE, 16'd4000, 16'd4001, 16'd512);
      wait_done("after_rst", 1'b0, 100);
      check("after_rst_q_empty", 32'(exp_q.size()), 32'd0);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
